// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow input in clock_in cycles, with lock and loss detection.
// Latency: results appear 4 cycles after the closing input rise; meas_valid holds until meas_ack (unacked results are overwritten and flag overrun).
module clock_period_meter #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 50000,
    parameter int LOCK_TOL   = 4,
    parameter int LOCK_COUNT = 8
) (
    input  logic             clock_in,
    input  logic             rst,
    input  logic             signal_in,
    input  logic             meas_ack,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             overrun,
    output logic             timeout,
    output logic             locked
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t            state;
    logic              sync1, sync2, sync3;
    logic              rise, fall;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  high_cap;
    logic [CNT_W-1:0]  prev_period;
    logic              have_prev;
    logic [MC_W-1:0]   match_cnt;
    logic [CNT_W:0]    cnt_ext, prev_ext, diff;
    logic              is_match;

    assign rise = sync2 & ~sync3;
    assign fall = ~sync2 & sync3;

    // One extra bit so the subtraction never wraps before taking the magnitude.
    assign cnt_ext  = {1'b0, cnt};
    assign prev_ext = {1'b0, prev_period};
    assign diff     = (cnt_ext >= prev_ext) ? (cnt_ext - prev_ext) : (prev_ext - cnt_ext);
    assign is_match = (diff <= (CNT_W+1)'(LOCK_TOL));

    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            cnt         <= '0;
            high_cap    <= '0;
            prev_period <= '0;
            have_prev   <= 1'b0;
            match_cnt   <= '0;
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
            locked      <= 1'b0;
        end else begin
            sync1 <= signal_in;
            sync2 <= sync1;
            sync3 <= sync2;

            // A load below overrides this, so an ack coinciding with new data keeps valid high.
            if (meas_ack) begin
                meas_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= MEASURE;
                        cnt   <= CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period      <= cnt;
                        high_time   <= high_cap;
                        meas_valid  <= 1'b1;
                        timeout     <= 1'b0;
                        if (meas_valid && !meas_ack) begin
                            overrun <= 1'b1;
                        end
                        cnt         <= CNT_W'(1);
                        prev_period <= cnt;
                        have_prev   <= 1'b1;
                        if (have_prev) begin
                            if (is_match) begin
                                if (match_cnt >= MC_W'(LOCK_COUNT - 1)) begin
                                    match_cnt <= MC_W'(LOCK_COUNT);
                                    locked    <= 1'b1;
                                end else begin
                                    match_cnt <= match_cnt + 1'b1;
                                end
                            end else begin
                                match_cnt <= '0;
                                locked    <= 1'b0;
                            end
                        end
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        have_prev <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (fall) begin
                            high_cap <= cnt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
Measures the period and high time of a slow external square wave, such as a divided transducer drive clock or a returned 40 kHz reference, in units of the fast system clock. It is the receive-side counterpart of the clock divider: the divider generates a slow clock, and this block recovers its timing. Each completed measurement is presented on a valid/ack handshake. The block also reports a lock status when successive periods agree, and a timeout when the input stops toggling.

Parameters:
CNT_W, 16, width of period/high-time counters and outputs
TIMEOUT, 50000, cycles without a rising edge before declaring input lost (must be < 2^CNT_W)
LOCK_TOL, 4, max |period - previous period| counted as a match
LOCK_COUNT, 8, consecutive matches required to assert locked

Ports:
clock_in  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low
signal_in  input  1  asynchronous slow input to measure
meas_ack  input  1  consumer accepts current measurement
period  output  CNT_W  last measured period, clock_in cycles
high_time  output  CNT_W  last measured high time, clock_in cycles
meas_valid  output  1  period/high_time hold an unconsumed measurement
overrun  output  1  sticky: a measurement was overwritten before ack
timeout  output  1  sticky: input lost; cleared by next valid measurement
locked  output  1  period stable within LOCK_TOL for LOCK_COUNT matches

Behaviour:
- Reset (rst=0, async): all outputs 0, counters 0, sync flops 0, state IDLE.
- Input path: 2-flop synchronizer, then a registered copy for edge detect. The rise/fall pulse occurs 3 clock_in cycles after the input edge.
- State machine:
  - IDLE: cnt holds 0. On a rise pulse, go to MEASURE with cnt<=1.
  - MEASURE: cnt<=cnt+1 each cycle.
  - Fall pulse in MEASURE: high_cap<=cnt.
  - Rise pulse in MEASURE: period<=cnt, high_time<=high_cap, meas_valid<=1 (next cycle), cnt<=1.
  - Result for a 50-cycle period with 25 cycles high: period=50, high_time=25.
  - cnt==TIMEOUT with no rise: go to IDLE, timeout<=1, locked<=0, match count<=0. period, high_time and meas_valid are unchanged.
- Handshake:
  - meas_valid stays high until a cycle with meas_ack=1. It deasserts the next cycle.
  - meas_ack while meas_valid=0 is ignored.
  - New measurement while meas_valid=1 and meas_ack=0: outputs overwritten, overrun<=1 (sticky until reset).
  - New measurement in the same cycle as meas_ack: new data loaded, meas_valid stays 1, no overrun.
- Timeout flag: cleared in the cycle a new measurement is loaded.
- Lock:
  - On each measurement after the first since IDLE, compare with the previous period (unsigned absolute difference, CNT_W+1 bits internally).
  - Match (diff <= LOCK_TOL): match count increments, saturating at LOCK_COUNT. locked<=1 when the count reaches LOCK_COUNT.
  - Mismatch: match count <=0, locked<=0.
  - The first measurement after IDLE only loads the previous-period register.
- Simultaneous events:
  - Rise pulse and cnt==TIMEOUT in the same cycle: the rise wins (measurement taken, no timeout).
  - A fall and a rise cannot coincide after edge detection.
- signal_in stuck high or low: no pulses, so timeout is reached; the block re-arms on the next rise.
- Reset mid-measurement: everything is cleared immediately, and the partial period is discarded.

Test Plan:
1. Reset: hold rst=0 while toggling signal_in -> all outputs 0. Release -> no meas_valid until the second rise.
2. Steady wave, 50-cycle period, 25 high, meas_ack pulsed after each valid -> period=50, high_time=25 every time. locked=1 after the 9th measurement. overrun=0.
3. Duty/jitter: alternate periods 50/53 (diff 3 <= 4) -> locked asserts. Then one 60-cycle period -> locked deasserts the next cycle and relocks after 8 more matches.
4. Handshake: never ack, 3 periods -> meas_valid=1, period=last value, overrun=1. Ack in the same cycle as the next load -> meas_valid remains 1, no additional effect.
5. Timeout with TIMEOUT=200: stop signal_in high after locking -> timeout=1 and locked=0 exactly 200 cycles after the last rise pulse, with the prior period retained. Restart the wave -> first valid after two rises, timeout clears.
6. Async reset mid-period: assert rst=0 between clock edges -> outputs clear without waiting for clock_in. After release, behaviour matches scenario 1.
